// File: rtl/dram_cmd_scheduler_if.sv
// dram_cmd_scheduler_if: host request/response channel of the DRAM command scheduler
interface dram_cmd_scheduler_if;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [9:0] req_row;
  logic [9:0] req_col;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_error;
  modport master (
    output req_valid, req_write, req_row, req_col, req_wdata,
    input req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error
  );
  modport slave (
    input req_valid, req_write, req_row, req_col, req_wdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: FIFO-buffered host front-end serialising reads, writes and refreshes into DRAM array opcode pulses
module dram_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int REF_INTERVAL = 64,
  parameter logic [7:0] TEMP_HOT = 8'd85,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  dram_cmd_scheduler_if.slave host,
  input logic [7:0] temp_in,
  output logic [1:0] opcode,
  output logic [9:0] row,
  output logic [9:0] column,
  output logic [31:0] data_in,
  output logic [7:0] temp,
  input logic [31:0] mem_data_out,
  input logic [1:0] mem_error,
  output logic busy,
  output logic [15:0] refresh_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(REF_INTERVAL);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_REF = 2'b11;
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT_RD, RESP} state_t;
  state_t state_q, state_d;
  logic [52:0] fifo_q [FIFO_DEPTH];
  logic [52:0] head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic ref_pending_q, ref_pending_d;
  logic [LW-1:0] wait_q, wait_d;
  logic [1:0] cmd_q, cmd_d, opcode_q, opcode_d;
  logic [9:0] row_q, row_d, col_q, col_d;
  logic [31:0] data_q, data_d, rsp_rdata_q, rsp_rdata_d;
  logic [7:0] temp_q, temp_d;
  logic rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [1:0] rsp_error_q, rsp_error_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic push, pop, take_ref, capture;
  assign host.req_ready = cnt_q != CW'(FIFO_DEPTH);
  always_comb begin
    head = fifo_q[rd_ptr_q];
    push = host.req_valid && host.req_ready;
    take_ref = state_q == IDLE && ref_pending_q;
    pop = state_q == IDLE && !ref_pending_q && cnt_q != '0;
    state_d = state_q;
    cmd_d = cmd_q;
    opcode_d = 2'b00;
    wait_d = wait_q;
    capture = 1'b0;
    ref_cnt_d = ref_cnt_q;
    case (state_q)
      IDLE: begin
        state_d = take_ref || pop ? ISSUE : IDLE;
        cmd_d = take_ref ? OP_REF : head[52] ? OP_WR : OP_RD;
        opcode_d = take_ref || pop ? cmd_d : 2'b00;
      end
      ISSUE: state_d = GAP;
      GAP: begin
        capture = cmd_q == OP_WR || (cmd_q == OP_RD && RD_LAT == 1);
        state_d = cmd_q == OP_REF ? IDLE : capture ? RESP : WAIT_RD;
        ref_cnt_d = ref_cnt_q + 16'(cmd_q == OP_REF);
        wait_d = LW'(RD_LAT > 1 ? RD_LAT - 2 : 0);
      end
      WAIT_RD: begin
        capture = wait_q == '0;
        state_d = capture ? RESP : WAIT_RD;
        wait_d = wait_q - LW'(!capture);
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    row_d = pop ? head[51:42] : row_q;
    col_d = pop ? head[41:32] : col_q;
    data_d = pop ? head[31:0] : data_q;
    temp_d = take_ref ? temp_in : temp_q;
    rsp_valid_d = capture;
    rsp_write_d = capture ? cmd_q == OP_WR : rsp_write_q;
    rsp_rdata_d = capture ? (cmd_q == OP_WR ? 32'h0 : mem_data_out) : rsp_rdata_q;
    rsp_error_d = capture ? mem_error : rsp_error_q;
    // the timer parks at zero so a refresh deferred behind a host command is not lost
    timer_d = take_ref ? (temp_in >= TEMP_HOT ? TW'(REF_INTERVAL / 2 - 1) : TW'(REF_INTERVAL - 1))
            : timer_q == '0 ? timer_q : timer_q - TW'(1);
    ref_pending_d = !take_ref && (ref_pending_q || timer_q <= TW'(1));
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {host.req_write, host.req_row, host.req_col, host.req_wdata};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      timer_q <= TW'(REF_INTERVAL - 1);
      ref_pending_q <= 1'b0;
      wait_q <= '0;
      cmd_q <= 2'b00;
      opcode_q <= 2'b00;
      row_q <= '0;
      col_q <= '0;
      data_q <= '0;
      temp_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= '0;
      ref_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      timer_q <= timer_d;
      ref_pending_q <= ref_pending_d;
      wait_q <= wait_d;
      cmd_q <= cmd_d;
      opcode_q <= opcode_d;
      row_q <= row_d;
      col_q <= col_d;
      data_q <= data_d;
      temp_q <= temp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end
  assign opcode = opcode_q;
  assign row = row_q;
  assign column = col_q;
  assign data_in = data_q;
  assign temp = temp_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_write = rsp_write_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign host.rsp_error = rsp_error_q;
  assign refresh_cnt = ref_cnt_q;
  assign busy = state_q != IDLE || cnt_q != '0;
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb_dram_cmd_scheduler: directed self-checking bench for dram_cmd_scheduler
module tb_dram_cmd_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] temp_in = 8'd30;
  logic [1:0] opcode;
  logic [1:0] mem_error = 2'b00;
  logic [9:0] row, column;
  logic [31:0] data_in, mem_data_out;
  logic [31:0] mem_fix = 32'h0;
  logic [7:0] temp;
  logic busy;
  logic mem_mode = 1'b0;
  logic [15:0] refresh_cnt;
  int n_cmp = 0;
  int n_err = 0;
  dram_cmd_scheduler_if bus();
  dram_cmd_scheduler dut (
    .clk(clk), .rst(rst), .host(bus), .temp_in(temp_in),
    .opcode(opcode), .row(row), .column(column), .data_in(data_in), .temp(temp),
    .mem_data_out(mem_data_out), .mem_error(mem_error),
    .busy(busy), .refresh_cnt(refresh_cnt)
  );
  // array stand-in: fixed read data, or data derived from the addressed row
  assign mem_data_out = mem_mode ? {22'h0, row} : mem_fix;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic req(input logic w, input logic [9:0] r, input logic [9:0] c, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_row = r;
    bus.req_col = c;
    bus.req_wdata = d;
  endtask
  initial begin
    logic [1:0] exp_op;
    logic exp_v, acc;
    int nrow;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_row = '0;
    bus.req_col = '0;
    bus.req_wdata = '0;
    do_reset();
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_row", 32'(row), 0);
    chk("rst_column", 32'(column), 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_temp", 32'(temp), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_write", 32'(bus.rsp_write), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_error", 32'(bus.rsp_error), 0);
    chk("rst_refresh_cnt", 32'(refresh_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    mem_error = 2'b10;
    req(1'b1, 10'd5, 10'd10, 32'h99973111);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("wr_opcode", 32'(opcode), 2);
    chk("wr_row", 32'(row), 5);
    chk("wr_column", 32'(column), 10);
    chk("wr_data_in", data_in, 32'h99973111);
    tick();
    chk("wr_gap_opcode", 32'(opcode), 0);
    chk("wr_gap_rsp_valid", 32'(bus.rsp_valid), 0);
    tick();
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("wr_rsp_write", 32'(bus.rsp_write), 1);
    chk("wr_rsp_error", 32'(bus.rsp_error), 2);
    chk("wr_rsp_rdata", bus.rsp_rdata, 0);
    tick();
    chk("wr_rsp_end", 32'(bus.rsp_valid), 0);
    mem_error = 2'b00;
    mem_fix = 32'h99973111;
    req(1'b0, 10'd5, 10'd10, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rd_opcode", 32'(opcode), 1);
    chk("rd_row", 32'(row), 5);
    chk("rd_column", 32'(column), 10);
    tick();
    chk("rd_gap_opcode", 32'(opcode), 0);
    chk("rd_gap_rsp_valid", 32'(bus.rsp_valid), 0);
    tick();
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'h99973111);
    chk("rd_rsp_error", 32'(bus.rsp_error), 0);
    chk("rd_rsp_write", 32'(bus.rsp_write), 0);
    tick();
    chk("rd_rsp_end", 32'(bus.rsp_valid), 0);
    chk("rd_busy_end", 32'(busy), 0);
    temp_in = 8'd30;
    do_reset();
    for (int k = 1; k <= 330; k++) begin
      tick();
      exp_op = (k inside {64, 128, 192, 256, 288, 320}) ? 2'b11 : 2'b00;
      chk("ref_opcode", 32'(opcode), 32'(exp_op));
      if (exp_op != 2'b00) chk("ref_temp", 32'(temp), k <= 192 ? 30 : 90);
      if (k == 200) begin
        chk("ref_cnt_cool", 32'(refresh_cnt), 3);
        temp_in = 8'd90;
      end
    end
    chk("ref_cnt_hot", 32'(refresh_cnt), 6);
    temp_in = 8'd30;
    mem_fix = 32'h12345678;
    do_reset();
    for (int k = 1; k <= 73; k++) begin
      tick();
      if (k == 61) req(1'b1, 10'd3, 10'd1, 32'hA5A5A5A5);
      if (k == 62) req(1'b0, 10'd4, 10'd2, 32'h0);
      if (k == 63) bus.req_valid = 1'b0;
      if (k >= 62) begin
        exp_op = k == 63 ? 2'b10 : k == 67 ? 2'b11 : k == 70 ? 2'b01 : 2'b00;
        chk("defer_opcode", 32'(opcode), 32'(exp_op));
        chk("defer_rsp_valid", 32'(bus.rsp_valid), (k == 65 || k == 72) ? 1 : 0);
      end
      if (k == 65) chk("defer_wr_rsp_write", 32'(bus.rsp_write), 1);
      if (k == 70) chk("defer_rd_row", 32'(row), 4);
      if (k == 72) begin
        chk("defer_rd_rsp_write", 32'(bus.rsp_write), 0);
        chk("defer_rd_rsp_rdata", bus.rsp_rdata, 32'h12345678);
      end
    end
    chk("defer_refresh_cnt", 32'(refresh_cnt), 1);
    mem_mode = 1'b1;
    do_reset();
    nrow = 1;
    acc = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (acc) begin
        nrow++;
        if (nrow > 5) bus.req_valid = 1'b0;
        else bus.req_row = 10'(nrow);
      end
      if (k == 62) req(1'b0, 10'd1, 10'd0, 32'h0);
      if (k == 64) chk("full_ref_opcode", 32'(opcode), 3);
      if (k == 65) chk("full_ready_before", 32'(bus.req_ready), 1);
      if (k == 66) chk("full_ready_full", 32'(bus.req_ready), 0);
      if (k == 67) chk("full_ready_after_pop", 32'(bus.req_ready), 1);
      if (k >= 66) begin
        exp_v = k >= 69 && k <= 85 && (k - 69) % 4 == 0;
        chk("full_rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
        if (exp_v) chk("full_rsp_order", bus.rsp_rdata, 32'((k - 69) / 4 + 1));
      end
      acc = bus.req_valid && bus.req_ready;
    end
    chk("full_busy_end", 32'(busy), 0);
    chk("full_refresh_cnt", 32'(refresh_cnt), 1);
    mem_mode = 1'b0;
    do_reset();
    req(1'b1, 10'd7, 10'd8, 32'h89973111);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("mid_opcode", 32'(opcode), 2);
    tick();
    chk("mid_gap_opcode", 32'(opcode), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_opcode", 32'(opcode), 0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_row", 32'(row), 0);
    for (int j = 1; j <= 64; j++) begin
      tick();
      chk("mid_after_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("mid_after_opcode", 32'(opcode), j == 64 ? 3 : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Command front-end that sits directly upstream of the Micron DRAM array model.
- Buffers host read/write requests in a small FIFO and serialises them into the array's one-cycle opcode pulses (00 idle, 01 read, 10 write, 11 refresh).
- Inserts periodic refresh at an interval that halves when the die is hot.
- Captures array read data and error flags and returns them to the host as one-cycle responses.

Parameters:
- FIFO_DEPTH, 4, host request FIFO entries (power of 2, ≥2)
- REF_INTERVAL, 64, cycles between refreshes when temp_in < TEMP_HOT
- TEMP_HOT, 8'd85, temperature threshold; at or above it the interval is REF_INTERVAL/2
- RD_LAT, 1, cycles from read pulse to valid mem_data_out/mem_error (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  FIFO not full; a push happens when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_row  in  10  row address
- req_col  in  10  column address
- req_wdata  in  32  write data (ignored for reads)
- temp_in  in  8  current die temperature
- rsp_valid  out  1  one-cycle response pulse; the host cannot stall it
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  32  read data (0 for writes)
- rsp_error  out  2  array error flags sampled with the response
- opcode  out  2  to array
- row  out  10  to array
- column  out  10  to array
- data_in  out  32  to array
- temp  out  8  to array; temp_in captured at refresh issue
- mem_data_out  in  32  from array data_out
- mem_error  in  2  from array error
- busy  out  1  FSM not in IDLE or FIFO not empty
- refresh_cnt  out  16  refreshes issued, wraps at 2^16

Behaviour:
- Reset values:
  - opcode=00; row, column, data_in, temp = 0.
  - rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_error=0.
  - refresh_cnt=0, busy=0.
  - FIFO empty, so req_ready=1.
  - Refresh timer = REF_INTERVAL-1; ref_pending=0.
- All array-facing outputs are registered. opcode is non-zero for exactly one cycle per command and is always followed by at least one cycle of 00.
- FIFO:
  - req_ready = !full (combinational from the count).
  - Push and pop in the same cycle are legal when not full; the count is unchanged.
  - No push is possible while full.
- Refresh timer:
  - Decrements every cycle.
  - At 0 it sets ref_pending and holds at 0 until the refresh is issued.
  - On issue it reloads to REF_INTERVAL-1, or REF_INTERVAL/2-1 if temp_in ≥ TEMP_HOT, sampled in the issue cycle.
- FSM states: IDLE, ISSUE, GAP, WAIT_RD, RESP.
  - IDLE: if ref_pending, go to ISSUE with a refresh. Else if the FIFO is not empty, pop to ISSUE with the request. Refresh wins ties.
  - ISSUE (1 cycle): drive opcode, row, column, data_in (and temp for a refresh). Next state is GAP.
  - GAP (1 cycle): opcode=00.
    - Write: sample mem_error, go to RESP.
    - Read with RD_LAT=1: sample mem_data_out and mem_error, go to RESP.
    - Read with RD_LAT>1: go to WAIT_RD.
    - Refresh: increment refresh_cnt, go to IDLE.
  - WAIT_RD: wait until RD_LAT cycles after ISSUE, sample data and error, go to RESP.
  - RESP (1 cycle): rsp_valid=1 with the captured rsp_write, rsp_rdata and rsp_error. Next state is IDLE.
- Latency:
  - A push at cycle A into an empty FIFO with the FSM in IDLE and no refresh pending gives an opcode pulse at A+2. That is one cycle to land in the FIFO and one for the IDLE decision register.
  - rsp_valid appears at pulse+2 for a write, and at pulse+RD_LAT+1 for a read.
- A refresh falling due mid-command is deferred. It is served in the first IDLE cycle after the current command's RESP, before the next FIFO pop. Host commands are never preempted.
- Row and column pass through unchanged. No address range check is done here; range checking is the array's job.
- rst asserted mid-command:
  - The next edge forces opcode=00 and the FSM to IDLE.
  - The FIFO is flushed and rsp_valid=0.
  - The in-flight command is lost with no response.

Test Plan:
- Write row=5, col=10, wdata=32'h99973111 on an idle block → opcode=10 for one cycle at push+2 with row=5, column=10, data_in=32'h99973111. Then opcode=00. rsp_valid=1, rsp_write=1, rsp_error=mem_error at pulse+2.
- Read row=5, col=10 with the array model returning 32'h99973111 and error=0 → opcode=01 pulse. rsp_valid at pulse+RD_LAT+1 with rsp_rdata=32'h99973111, rsp_error=2'b00, rsp_write=0.
- temp_in=30 and no traffic for 200 cycles → opcode=11 pulses 64 cycles apart, temp=30 on each, refresh_cnt=3. Then set temp_in=90 → later pulses are 32 cycles apart.
- Refresh falls due while a write is in ISSUE → the write completes, its RESP occurs, then opcode=11 on the next ISSUE, then the queued read. No command is dropped.
- While busy, push 4 requests, then hold req_valid=1 → req_ready=0 after the 4th push. It returns to 1 the cycle after the first pop. All 5 responses arrive in order.
- Write row=7, col=8, wdata=32'h89973111; assert rst on the GAP cycle → opcode=00 next edge, no rsp_valid, FIFO empty, req_ready=1, timer reloaded to REF_INTERVAL-1.
